// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if : byte-stream, control and IMemory write bundle of imem_loader
// Rev 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
   parameter int ADDR_W = 10
) ();
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : length-prefixed byte stream -> 32-bit IMemory words from addr 0
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  wire logic    clock,
   input  wire logic    reset_n,
   imem_loader_if.slave bus
);
   localparam logic [16:0] c_DEPTH = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t            r_state;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_len;
   logic [15:0]       r_word_cnt;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_word;
   logic              r_in_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_hold;
   logic              r_done;
   logic              r_error;

   logic              w_xfer;
   logic [15:0]       w_len;
   logic [15:0]       w_word_nxt;

   assign w_xfer     = bus.in_valid & r_in_ready;
   assign w_len      = {r_len_hi, bus.in_data};
   assign w_word_nxt = r_word_cnt + 16'd1;

   // Outputs are registered alongside the state, so each is set on entry to the
   // state that owns it rather than decoded from r_state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_len_hi   <= 8'd0;
         r_len      <= 16'd0;
         r_word_cnt <= 16'd0;
         r_byte_cnt <= 2'd0;
         r_word     <= 24'd0;
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state    <= S_LEN_HI;
                  r_in_ready <= 1'b1;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len_hi <= bus.in_data;
                  r_state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len      <= w_len;
                  r_word_cnt <= 16'd0;
                  r_byte_cnt <= 2'd0;
                  if (w_len == 16'd0) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                     r_hold     <= 1'b0;
                  end else if ({1'b0, w_len} > c_DEPTH) begin
                     r_state    <= S_ERR;
                     r_in_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_word     <= {r_word[15:0], bus.in_data};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  // byte_cnt wraps back to 0 here, ready for the next word
                  if (r_byte_cnt == 2'd3) begin
                     r_state    <= S_WRITE;
                     r_in_ready <= 1'b0;
                     r_we       <= 1'b1;
                     r_addr     <= r_word_cnt[ADDR_W-1:0];
                     r_wdata    <= {r_word, bus.in_data};
                  end
               end
            end
            S_WRITE: begin
               r_word_cnt <= w_word_nxt;
               if (w_word_nxt == r_len) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
               end else begin
                  r_state    <= S_DATA;
                  r_in_ready <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.start) begin
                  r_state    <= S_LEN_HI;
                  r_in_ready <= 1'b1;
                  r_done     <= 1'b0;
                  r_hold     <= 1'b1;
               end
            end
            S_ERR: begin
               if (bus.start) begin
                  r_state    <= S_LEN_HI;
                  r_in_ready <= 1'b1;
                  r_error    <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.cpu_hold   = r_hold;
   assign bus.done       = r_done;
   assign bus.error      = r_error;
endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : scoreboard bench for imem_loader (writes checked at strobe)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;
   localparam int ADDR_W = 10;

   typedef logic [7:0] byte_q_t[$];

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   int                   checks   = 0;
   int                   errors   = 0;
   int                   n_writes = 0;
   logic [ADDR_W-1:0]    last_addr = '0;
   logic                 prev_we  = 1'b0;
   logic [ADDR_W+31:0]   exp_q[$];

   // Every strobe pops one expected {addr, data}
   always @(negedge clock) begin
      logic [ADDR_W+31:0] exp_w;
      if (bus.imem_we === 1'b1) begin
         n_writes++;
         last_addr = bus.imem_addr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, no write required",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            if ({bus.imem_addr, bus.imem_wdata} !== exp_w) begin
               errors++;
               $display("FAIL write_word: got addr=%h data=%h, required addr=%h data=%h",
                        bus.imem_addr, bus.imem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
            end
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_write: got in_ready=%b, required 0", bus.in_ready);
         end
         checks++;
         if (prev_we !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: imem_we high two cycles in a row, required one");
         end
      end
      prev_we = bus.imem_we;
   end

   task automatic bus_idle();
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.start    = 1'b1;
      @(negedge clock);
      bus.start    = 1'b0;
   endtask

   // Byte is transferred on the posedge following the negedge where it is driven with in_ready=1
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n = 0;
      forever begin
         @(negedge clock);
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            if (bus.in_ready === 1'b1) break;
         end
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: in_ready stayed 0 for byte %h, required 1", b);
            bus.in_valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic send_image(input byte_q_t bytes, input bit gaps);
      foreach (bytes[i]) send_byte(bytes[i], gaps);
      bus_idle();
   endtask

   task automatic wait_flag();
      int n = 0;
      while (!(bus.done === 1'b1 || bus.error === 1'b1)) begin
         @(negedge clock);
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL flag_timeout: done=%b error=%b, required done or error", bus.done, bus.error);
            break;
         end
      end
   endtask

   task automatic load_t2(input bit gaps);
      byte_q_t b;
      b = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
      pulse_start();
      exp_q.push_back({10'h000, 32'h8C010004});
      exp_q.push_back({10'h001, 32'h00221820});
      send_image(b, gaps);
      wait_flag();
   endtask

   task automatic test_reset();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset_n      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if ({bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: got rdy/we/hold/done/err=%b, required 00100",
                     {bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error});
         end
         checks++;
         if ({bus.imem_addr, bus.imem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", bus.imem_addr, bus.imem_wdata);
         end
      end
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.cpu_hold} !== 2'b01) begin
         errors++;
         $display("FAIL idle_after_reset: got in_ready=%b cpu_hold=%b, required 0 1",
                  bus.in_ready, bus.cpu_hold);
      end
   endtask

   task automatic test_basic();
      int w0 = n_writes;
      load_t2(1'b0);
      checks++;
      if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100) begin
         errors++;
         $display("FAIL basic_flags: got done/hold/err=%b, required 100",
                  {bus.done, bus.cpu_hold, bus.error});
      end
      checks++;
      if (n_writes - w0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_count: got %0d writes (%0d pending), required 2 (0)",
                  n_writes - w0, exp_q.size());
      end
   endtask

   task automatic test_gaps();
      int w0 = n_writes;
      load_t2(1'b1);
      checks++;
      if ({bus.done, bus.cpu_hold} !== 2'b10) begin
         errors++;
         $display("FAIL gaps_flags: got done=%b hold=%b, required 1 0", bus.done, bus.cpu_hold);
      end
      checks++;
      if (n_writes - w0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL gaps_count: got %0d writes (%0d pending), required 2 (0)",
                  n_writes - w0, exp_q.size());
      end
   endtask

   task automatic test_edges();
      byte_q_t b;
      int w0;
      logic [31:0] w;
      // len = 0
      w0 = n_writes;
      pulse_start();
      b = '{8'h00, 8'h00};
      send_image(b, 1'b0);
      wait_flag();
      repeat (3) @(negedge clock);
      checks++;
      if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100 || n_writes != w0) begin
         errors++;
         $display("FAIL len0: got done/hold/err=%b writes=%0d, required 100 writes=0",
                  {bus.done, bus.cpu_hold, bus.error}, n_writes - w0);
      end
      // len = 0x0401, one past depth
      pulse_start();
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL restart_done: got done=%b, required 0", bus.done);
      end
      b = '{8'h04, 8'h01};
      send_image(b, 1'b0);
      wait_flag();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      repeat (4) @(negedge clock);
      checks++;
      if ({bus.error, bus.cpu_hold, bus.done, bus.in_ready} !== 4'b1100 || n_writes != w0) begin
         errors++;
         $display("FAIL len_over: got err/hold/done/rdy=%b writes=%0d, required 1100 writes=0",
                  {bus.error, bus.cpu_hold, bus.done, bus.in_ready}, n_writes - w0);
      end
      // len = 0x0400, fills memory exactly
      pulse_start();
      checks++;
      if (bus.error !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got error=%b, required 0", bus.error);
      end
      b = '{8'h04, 8'h00};
      for (int i = 0; i < 1024; i++) begin
         w = 32'(i) * 32'h9E3779B1;
         b.push_back(w[31:24]);
         b.push_back(w[23:16]);
         b.push_back(w[15:8]);
         b.push_back(w[7:0]);
         exp_q.push_back({10'(i), w});
      end
      w0 = n_writes;
      send_image(b, 1'b0);
      wait_flag();
      checks++;
      if (n_writes - w0 != 1024 || last_addr !== 10'h3FF || exp_q.size() != 0) begin
         errors++;
         $display("FAIL len_full: got %0d writes last_addr=%h, required 1024 last_addr=3ff",
                  n_writes - w0, last_addr);
      end
      checks++;
      if ({bus.done, bus.cpu_hold, bus.error} !== 3'b100) begin
         errors++;
         $display("FAIL full_flags: got done/hold/err=%b, required 100",
                  {bus.done, bus.cpu_hold, bus.error});
      end
   endtask

   task automatic test_abort();
      byte_q_t b;
      int w0 = n_writes;
      pulse_start();
      b = '{8'h00, 8'h02, 8'h8C, 8'h01};
      foreach (b[i]) send_byte(b[i], 1'b0);
      @(posedge clock);
      #2;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error} !== 5'b00100) begin
         errors++;
         $display("FAIL abort_async: got rdy/we/hold/done/err=%b, required 00100",
                  {bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error});
      end
      repeat (2) @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.imem_we, bus.cpu_hold} !== 3'b001) begin
         errors++;
         $display("FAIL abort_hold: got rdy/we/hold=%b, required 001",
                  {bus.in_ready, bus.imem_we, bus.cpu_hold});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (n_writes != w0) begin
         errors++;
         $display("FAIL abort_nowrite: got %0d writes, required 0", n_writes - w0);
      end
      load_t2(1'b0);
      checks++;
      if (n_writes - w0 != 2 || bus.done !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_reload: got %0d writes done=%b, required 2 writes done=1",
                  n_writes - w0, bus.done);
      end
   endtask

   task automatic test_reload();
      byte_q_t b;
      int w0 = n_writes;
      pulse_start();
      checks++;
      if ({bus.cpu_hold, bus.done, bus.in_ready} !== 3'b101) begin
         errors++;
         $display("FAIL reload_hold: got hold/done/rdy=%b, required 101",
                  {bus.cpu_hold, bus.done, bus.in_ready});
      end
      exp_q.push_back({10'h000, 32'h20080005});
      b = '{8'h00, 8'h01, 8'h20, 8'h08};
      foreach (b[i]) send_byte(b[i], 1'b0);
      pulse_start();
      checks++;
      if ({bus.in_ready, bus.done, bus.cpu_hold} !== 3'b101) begin
         errors++;
         $display("FAIL start_in_data: got rdy/done/hold=%b, required 101",
                  {bus.in_ready, bus.done, bus.cpu_hold});
      end
      b = '{8'h00, 8'h05};
      send_image(b, 1'b0);
      wait_flag();
      checks++;
      if ({bus.done, bus.cpu_hold} !== 2'b10 || n_writes - w0 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload_done: got done=%b hold=%b writes=%0d, required 1 0 writes=1",
                  bus.done, bus.cpu_hold, n_writes - w0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_edges();
      test_abort();
      test_reload();
      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
